// File: rtl/fetch_queue_pkg.sv
// Shared fetch constants: reset PC default, word geometry, NOP encoding.
package fetch_queue_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int          WORD_BYTES       = 4;
  localparam int          INSTR_W          = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_entry_ram.sv
// Fetch queue storage: pc4/instr per entry plus filled flags, with separate
// allocate, fill, clear and read ports.
module fetch_entry_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc_we,
  input  logic [PW-1:0]      alloc_idx,
  input  logic [31:0]        alloc_pc4,
  input  logic               fill_we,
  input  logic [PW-1:0]      fill_idx,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic               clr_we,
  input  logic [PW-1:0]      clr_idx,
  input  logic [PW-1:0]      rd_idx,
  output logic [31:0]        rd_pc4,
  output logic [INSTR_W-1:0] rd_instr,
  output logic               rd_filled
);

  logic [31:0]        pc4_mem   [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0]   filled;

  always_ff @(posedge clk) begin
    if (alloc_we) pc4_mem[alloc_idx] <= alloc_pc4;
    if (fill_we)  instr_mem[fill_idx] <= fill_data;
  end

  // Alloc, fill and clear never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      filled <= '0;
    end else begin
      if (alloc_we) filled[alloc_idx] <= 1'b0;
      if (fill_we)  filled[fill_idx]  <= 1'b1;
      if (clr_we)   filled[clr_idx]   <= 1'b0;
    end
  end

  assign rd_pc4    = pc4_mem[rd_idx];
  assign rd_instr  = instr_mem[rd_idx];
  assign rd_filled = filled[rd_idx];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests,
// queues responses and hands them to IF/ID; redirects flush and drop in-flight data.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc4_o,
  input  logic        id_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(2 * DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [PW-1:0] head_ptr, alloc_ptr, fill_ptr;
  logic [CW-1:0] count;      // allocated entries
  logic [CW-1:0] pend_cnt;   // allocated but not yet filled
  logic [DW-1:0] drop_cnt;
  logic [DW-1:0] drop_next;

  logic          accept, fill_we, pop;
  logic          rd_filled;
  logic [31:0]   rd_pc4, rd_instr;

  assign imem_req_o  = ~rst_i & ~redirect_i & (count < CW'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign accept      = imem_req_o & imem_ready_i;

  // A response with nothing pending and nothing to drop is ignored.
  assign fill_we = imem_rvalid_i & ~rst_i & ~redirect_i &
                   (drop_cnt == '0) & (pend_cnt != '0);

  assign id_valid_o = rd_filled & ~redirect_i & ~rst_i;
  assign id_instr_o = rd_filled ? rd_instr : NOP_INSTR;
  assign id_pc4_o   = rd_pc4;
  assign pop        = id_valid_o & id_ready_i;

  // On redirect every still-unfilled request becomes a response to discard.
  always_comb begin
    drop_next = drop_cnt + DW'(pend_cnt);
    if (imem_rvalid_i && drop_next != '0) drop_next = drop_next - DW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc  <= PC_RESET;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (redirect_i) begin
      fetch_pc  <= word_align(redirect_pc_i);
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_next;
    end else begin
      if (accept) begin
        fetch_pc  <= fetch_pc + 32'(WORD_BYTES);
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (fill_we) fill_ptr <= fill_ptr + PW'(1);
      if (pop)     head_ptr <= head_ptr + PW'(1);
      count    <= count + CW'(accept) - CW'(pop);
      pend_cnt <= pend_cnt + CW'(accept) - CW'(fill_we);
      if (imem_rvalid_i && drop_cnt != '0) drop_cnt <= drop_cnt - DW'(1);
    end
  end

  fetch_entry_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (redirect_i),
    .alloc_we  (accept),
    .alloc_idx (alloc_ptr),
    .alloc_pc4 (fetch_pc + 32'(WORD_BYTES)),
    .fill_we   (fill_we),
    .fill_idx  (fill_ptr),
    .fill_data (imem_rdata_i),
    .clr_we    (pop),
    .clr_idx   (head_ptr),
    .rd_idx    (head_ptr),
    .rd_pc4    (rd_pc4),
    .rd_instr  (rd_instr),
    .rd_filled (rd_filled)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: pipelined memory model, expected-stream scoreboard,
// directed timing checks and a randomized run with redirects and stalls.
module tb_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc4;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RST)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ready_i  (imem_ready),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .id_valid_o    (id_valid),
    .id_instr_o    (id_instr),
    .id_pc4_o      (id_pc4),
    .id_ready_i    (id_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  // Expected delivery stream: consecutive words starting at the last fetch target.
  typedef struct { logic [31:0] pc4; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] sb_pc;

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    sb_pc = {pc[31:2], 2'b00};
  endtask

  task automatic sb_topup();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc4   = sb_pc + 32'd4;
      e.instr = mem_word(sb_pc);
      exp_q.push_back(e);
      sb_pc = sb_pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && id_valid && id_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got pc4 0x%08h, want no delivery", id_pc4);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc4", id_pc4, e.pc4);
        chk("sb_instr", id_instr, e.instr);
      end
    end
  end

  // Pipelined in-order memory: each accepted request answers lat cycles later.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    last_due = 0;
  int    lat = 1;
  int    ready_pct = 100;

  always @(negedge clk) begin
    mreq_t r;
    if (rst) begin
      mq.delete();
    end else if (imem_req && imem_ready) begin
      r.addr = imem_addr;
      r.due  = cyc + lat;
      if (mq.size() > 0 && r.due <= last_due) r.due = last_due + 1;
      mq.push_back(r);
      last_due = r.due;
    end
  end

  initial begin
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq[0].addr);
        mq.delete(0);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      imem_ready = ($urandom_range(99) < ready_pct);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    sb_topup();
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pop(input int budget, input string name);
    int p = n_pop;
    int k = 0;
    while (n_pop == p && k < budget) begin
      step();
      sample();
      k++;
    end
    chk(name, 32'(n_pop > p), 32'd1);
  endtask

  // Reset, then leave the bench at C0 with the stream restarted.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    step();
    rst = 1'b0;
    sb_restart(PC_RST);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    step();
    redirect    = 1'b1;
    redirect_pc = pc;
    sb_restart(pc);
  endtask

  initial begin
    int p0;
    rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    sb_restart(PC_RST);

    repeat (3) begin
      step(); sample();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(id_valid), 32'd0);
    end

    // Reset release, zero-wait memory
    step(); rst = 1'b0; sb_restart(PC_RST);
    sample();
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_addr", imem_addr, PC_RST);
    step(); sample();
    chk("c1_valid", 32'(id_valid), 32'd0);
    step(); sample();
    chk("c2_valid", 32'(id_valid), 32'd1);
    chk("c2_pc4", id_pc4, PC_RST + 32'd4);
    p0 = n_pop;
    repeat (10) step();
    sample();
    chk("steady_rate", 32'(n_pop - p0), 32'd10);

    // Decode stall of 10 cycles right after the first delivery
    do_reset();
    step(); step(); sample();
    step(); id_ready = 1'b0;
    repeat (10) step();
    sample();
    chk("stall_valid", 32'(id_valid), 32'd1);
    chk("stall_pc4", id_pc4, PC_RST + 32'd8);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_count", 32'(dut.count), DEPTH);
    step(); id_ready = 1'b1; p0 = n_pop;
    repeat (19) step();
    sample();
    chk("drain_rate", 32'(n_pop - p0), 32'd20);

    // Redirect with three responses in flight
    lat = 3;
    repeat (12) step();
    do_redirect(32'h40);
    sample();
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd0);
    step(); redirect = 1'b0;
    sample();
    chk("redir_t1_req", 32'(imem_req), 32'd1);
    chk("redir_t1_addr", imem_addr, 32'h40);
    wait_pop(12, "redir_deliver");

    // Back-to-back redirects
    repeat (6) step();
    do_redirect(32'h40);
    step(); redirect_pc = 32'h80; sb_restart(32'h80);
    sample();
    chk("dbl_valid", 32'(id_valid), 32'd0);
    step(); redirect = 1'b0;
    sample();
    chk("dbl_addr", imem_addr, 32'h80);
    wait_pop(12, "dbl_deliver");
    repeat (15) step();
    sample();
    chk("dbl_drop_zero", 32'(dut.drop_cnt), 32'd0);

    // Redirect colliding with a response and a ready head
    lat = 1;
    repeat (8) step();
    sample();
    p0 = n_pop;
    do_redirect(32'h200);
    sample();
    chk("coll_rvalid", 32'(imem_rvalid & id_ready), 32'd1);
    chk("coll_valid", 32'(id_valid), 32'd0);
    chk("coll_nopop", 32'(n_pop - p0), 32'd0);
    step(); redirect = 1'b0;
    wait_pop(12, "coll_deliver");

    // Address wrap; low redirect bits ignored
    repeat (4) step();
    do_redirect(32'hFFFF_FFFE);
    step(); redirect = 1'b0;
    sample();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_pop(12, "wrap_deliver");
    repeat (6) step();

    // Randomized run
    ready_pct = 75;
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i % 100 == 0) lat = 1 + $urandom_range(3);
      id_ready = ($urandom_range(99) < 70);
      redirect = ($urandom_range(39) == 0);
      if (redirect) begin
        redirect_pc = $urandom;
        sb_restart(redirect_pc);
      end
    end
    step();
    redirect = 1'b0; id_ready = 1'b1; ready_pct = 100;
    wait_pop(20, "rand_final_deliver");
    repeat (20) step();
    sample();
    chk("rand_throughput", 32'(n_pop - p0 > 400), 32'd1);
    chk("rand_drop_zero", 32'(dut.drop_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks done", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
